// File: rtl/tern_pkg.sv
// Shared definitions for the ternary dot-product sequencer.
//   TERN_* : 2-bit ternary weight codes (2'b10 is reserved and weighs 0)
//   state_e: sequencer FSM states
//   acc_width(): accumulator width that cannot overflow for VEC_LEN products
package tern_pkg;

  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;
  localparam logic [1:0] TERN_ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_e;

  // One extra bit covers +128 from negating -128; log2(vec_len) bits cover
  // the growth from summing vec_len such terms.
  function automatic int acc_width(input int data_w, input int vec_len);
    return data_w + 1 + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/tern_negate_acc.sv
// Single negate-and-accumulate lane.
//   clk, rst : clock, synchronous active-high reset
//   valid    : act/code carry a data beat this cycle
//   act      : signed activation
//   code     : ternary weight code (+1 / -1 / 0)
//   clr      : clear the accumulator (wins over valid)
//   acc      : registered signed running sum
module tern_negate_acc
  import tern_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] act,
  input  logic [1:0]        code,
  input  logic              clr,
  output logic [ACC_W-1:0]  acc
);

  logic [DATA_W:0]  x_ext;
  logic [DATA_W:0]  term;
  logic [ACC_W-1:0] term_ext;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;

  always_comb begin
    // Widen by one bit first so that negating -128 yields an exact +128.
    x_ext = {act[DATA_W-1], act};
    case (code)
      TERN_POS:  term = x_ext;
      TERN_NEG:  term = -x_ext;
      TERN_ZERO: term = '0;
      default:   term = '0;  // reserved code contributes nothing
    endcase
    term_ext = {{(ACC_W-DATA_W-1){term[DATA_W]}}, term};

    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (valid) begin
      acc_d = acc_q + term_ext;
    end
  end

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its neighbours regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/tern_dot_sequencer.sv
// Sequences one ternary dot product sum(act[i]*w[i]), i = 0..n-1, over a
// shared memory read port, feeding a single negate-and-accumulate lane.
//   clk, rst           : clock, synchronous active-high reset
//   start, len         : begin a run of min(len, VEC_LEN) elements (IDLE only)
//   rd_req, rd_gnt     : read handshake; a read happens on rd_req && rd_gnt
//   rd_addr            : element index of the pending read
//   act_data, wgt_code : returned beat, valid one cycle after a granted read
//   busy               : run in progress (FETCH/DRAIN)
//   done, result       : one-cycle completion pulse; result held afterwards
module tern_dot_sequencer
  import tern_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int VEC_LEN = 4096,
  parameter int LEN_W   = $clog2(VEC_LEN) + 1,
  parameter int ADDR_W  = $clog2(VEC_LEN),
  parameter int ACC_W   = acc_width(DATA_W, VEC_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] act_data,
  input  logic [1:0]        wgt_code,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  n_q, n_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              beat_q, beat_d;

  logic [LEN_W-1:0]  len_clamped;
  logic              last_addr;
  logic              acc_clr;
  logic [ACC_W-1:0]  acc;

  assign len_clamped = (len > LEN_W'(VEC_LEN)) ? LEN_W'(VEC_LEN) : len;
  // Only evaluated in FETCH, where n_q >= 1.
  assign last_addr   = ({1'b0, rd_addr_q} == (n_q - LEN_W'(1)));

  // NOTE: every signal driven here gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    rd_addr_d = rd_addr_q;
    result_d  = result_q;
    acc_clr   = 1'b0;
    beat_d    = (state_q == FETCH) && rd_gnt;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d       = len_clamped;
          rd_addr_d = '0;
          acc_clr   = 1'b1;
          state_d   = (len_clamped == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (rd_gnt) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          if (last_addr) begin
            state_d = DRAIN;
          end
        end
      end
      // The final beat is registered into the lane on this edge.
      DRAIN: state_d = DONE;
      DONE: begin
        result_d = acc;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      rd_addr_q <= '0;
      result_q  <= '0;
      beat_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      rd_addr_q <= rd_addr_d;
      result_q  <= result_d;
      beat_q    <= beat_d;
    end
  end

  tern_negate_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_lane (
    .clk   (clk),
    .rst   (rst),
    .valid (beat_q),
    .act   (act_data),
    .code  (wgt_code),
    .clr   (acc_clr),
    .acc   (acc)
  );

  assign rd_req  = (state_q == FETCH);
  assign rd_addr = rd_addr_q;
  assign busy    = (state_q == FETCH) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  // The lane settles on the edge entering DONE, so the pulse cycle shows
  // the live accumulator; result_q keeps it afterwards.
  assign result  = (state_q == DONE) ? acc : result_q;

endmodule

// File: doc/tern_dot_sequencer.md
# tern_dot_sequencer

Controller that sequences one ternary dot product, sum(act[i] * w[i]) for i = 0..len-1, in the BitNet 1.58 vector-multiply layer. It walks a shared activation/weight memory port under a request/grant handshake and routes each signed int8 activation through a pass/negate/zero select. It accumulates into a widened signed accumulator and reports the result with a start/busy/done handshake. It sits between the layer control and the vector memory. It replaces the bulk per-element negation of whole vectors with one negate-and-accumulate lane reused over time.

## Interface
- DATA_W, 8, activation width (signed two's complement)
- VEC_LEN, 4096, maximum vector length
- LEN_W, $clog2(VEC_LEN)+1, width of len
- ADDR_W, $clog2(VEC_LEN), memory address width
- ACC_W, DATA_W+1+$clog2(VEC_LEN), accumulator/result width; guarantees no overflow

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a dot product; sampled only in IDLE
- len  in  LEN_W  element count, sampled with start
- rd_req  out  1  memory read request
- rd_gnt  in  1  grant from memory arbiter; a read occurs when rd_req && rd_gnt
- rd_addr  out  ADDR_W  element index of current request
- act_data  in  DATA_W  activation; valid exactly 1 cycle after a granted read
- wgt_code  in  2  ternary weight, same timing as act_data: 2'b01 = +1, 2'b11 = -1, 2'b00/2'b10 = 0
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse; result valid in the same cycle
- result  out  ACC_W  signed dot product; held until next accepted start

## Operation
- Reset values: rd_req=0, rd_addr=0, busy=0, done=0, result=0, accumulator=0, FSM in IDLE.
- FSM states:
  - IDLE: on start, latch n=min(len, VEC_LEN) and clear the accumulator. If n==0, go to DONE. Otherwise go to FETCH with busy=1.
  - FETCH: assert rd_req and hold rd_addr. On grant, increment rd_addr. After the grant for address n-1, go to DRAIN.
  - DRAIN: wait for the last data beat to be accumulated, then go to DONE.
  - DONE: done=1 and result=accumulator for one cycle, busy=0, then return to IDLE.
- rd_addr and rd_req are stable while rd_req && !rd_gnt. rd_req never exceeds n granted reads.
- Data beat, registered one cycle after each granted read:
  - Sign-extend act_data to DATA_W+1.
  - Term = +x for code 01, -x for code 11, 0 otherwise. -(-128) = +128 is exact.
  - Sign-extend the term to ACC_W and add it to the accumulator.
- start while busy is ignored; len changes while busy have no effect.
- start in the DONE cycle is ignored; start is accepted from the next IDLE cycle.
- rst mid-operation: return to IDLE next edge with reset values. No done pulse is produced and the partial result is discarded.
- A wgt_code of 2'b10 is reserved and contributes 0. No error flag is raised.

## Timing
- With rd_gnt held high and start accepted at cycle 0 (n>0):
  - rd_req is high for cycles 1..n, addresses 0..n-1.
  - Data arrives cycles 2..n+1.
  - done pulses at cycle n+2. Latency is n+2.
- Each cycle rd_gnt is low during FETCH adds exactly one cycle to latency.
- n==0: done at cycle 1, result=0, rd_req never asserted.
- len > VEC_LEN: clamped; exactly VEC_LEN reads are issued.
- Throughput: one element per granted cycle, no bubbles between beats.

## Structure
- Package tern_pkg:
  - TERN_POS/TERN_NEG/TERN_ZERO code constants
  - FSM state enum {IDLE, FETCH, DRAIN, DONE}
  - ACC_W derivation
- Sub-module tern_negate_acc: registered select/negate/sign-extend/add lane, with inputs valid, act, code, clr and output acc.
- The top level holds the FSM, address counter, grant handling and result register.

## Test plan
- len=4, act={10,-11,-127,127}, w={+1,-1,-1,+1}, rd_gnt=1 -> done at cycle 6, result=10+11+127+127=275, rd_addr sequence 0..3.
- len=1, act=-128, w=-1 -> result=+128, no wrap. Then len=VEC_LEN, all act=-128, all w=-1 -> result=524288, which fits ACC_W=21.
- len=3, rd_gnt deasserted for 2 cycles mid-run -> rd_addr/rd_req held during the stall, done at cycle 7, result matches the ideal run.
- len=0 -> done at cycle 1, result=0, rd_req never high. Also start asserted while busy -> ignored and the result is unaffected.
- rst asserted at cycle 3 of a len=8 run -> busy=0 and result=0 next edge, no done. A following len=2 run (act={5,5}, w={+1,2'b10}) -> result=5.
